// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two completion sources (EX, SLB), each with a small FIFO
// and same-cycle bypass, round-robin arbitrated onto one registered broadcast bus.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int NICK_W     = 6,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iEX_en,
  input  logic [NICK_W-1:0] iEX_nick,
  input  logic [DATA_W-1:0] iEX_dt,
  input  logic              iSLB_en,
  input  logic [NICK_W-1:0] iSLB_nick,
  input  logic [DATA_W-1:0] iSLB_dt,
  output logic              oEX_full,
  output logic              oSLB_full,
  output logic              oCDB_en,
  output logic [NICK_W-1:0] oCDB_nick,
  output logic [DATA_W-1:0] oCDB_dt,
  output logic              oCDB_src,
  output logic              oERR_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(FIFO_DEPTH - 1);

  // Index 0 is EX, index 1 is SLB; this matches the oCDB_src encoding.
  logic              in_en   [2];
  logic [NICK_W-1:0] in_nick [2];
  logic [DATA_W-1:0] in_dt   [2];

  logic [NICK_W-1:0] mem_nick [2][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_dt   [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  rptr [2];
  logic [PTR_W-1:0]  wptr [2];
  logic [CNT_W-1:0]  cnt  [2];
  logic              full_q [2];
  logic              prio;

  logic              acc      [2];
  logic              has_head [2];
  logic              cand     [2];
  logic [NICK_W-1:0] cand_nick[2];
  logic [DATA_W-1:0] cand_dt  [2];
  logic              pop      [2];
  logic              byp      [2];
  logic              push     [2];
  logic              drop     [2];
  logic [CNT_W-1:0]  cnt_nxt  [2];
  logic              gnt_any;
  logic              gnt_src;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + 1'b1;
  endfunction

  assign in_en[0]   = iEX_en;
  assign in_en[1]   = iSLB_en;
  assign in_nick[0] = iEX_nick;
  assign in_nick[1] = iSLB_nick;
  assign in_dt[0]   = iEX_dt;
  assign in_dt[1]   = iSLB_dt;

  assign oEX_full  = full_q[0];
  assign oSLB_full = full_q[1];

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      acc[s]       = in_en[s] && (in_nick[s] != '0);
      has_head[s]  = (cnt[s] != '0);
      cand[s]      = has_head[s] || acc[s];
      cand_nick[s] = has_head[s] ? mem_nick[s][rptr[s]] : in_nick[s];
      cand_dt[s]   = has_head[s] ? mem_dt[s][rptr[s]]   : in_dt[s];
    end
    gnt_any = cand[0] || cand[1];
    gnt_src = (cand[0] && cand[1]) ? prio : cand[1];
    for (int s = 0; s < 2; s++) begin
      pop[s]     = gnt_any && (gnt_src == 1'(s)) && has_head[s];
      byp[s]     = gnt_any && (gnt_src == 1'(s)) && !has_head[s];
      // A full FIFO still accepts when its head leaves in the same cycle.
      drop[s]    = acc[s] && !byp[s] && (cnt[s] == DEPTH_C) && !pop[s];
      push[s]    = acc[s] && !byp[s] && !drop[s];
      cnt_nxt[s] = cnt[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
    end
  end

  // Broadcast stage: control state and the registered bus
  always_ff @(posedge clk) begin
    if (rst || (rdy && clr)) begin
      for (int s = 0; s < 2; s++) begin
        cnt[s]    <= '0;
        rptr[s]   <= '0;
        wptr[s]   <= '0;
        full_q[s] <= 1'b0;
      end
      prio      <= 1'b0;
      oERR_ovf  <= 1'b0;
      oCDB_en   <= 1'b0;
      oCDB_nick <= '0;
      oCDB_dt   <= '0;
      oCDB_src  <= 1'b0;
    end else if (rdy) begin
      for (int s = 0; s < 2; s++) begin
        cnt[s]    <= cnt_nxt[s];
        full_q[s] <= (cnt_nxt[s] >= FULL_TH);
        if (pop[s])  rptr[s] <= ptr_inc(rptr[s]);
        if (push[s]) wptr[s] <= ptr_inc(wptr[s]);
      end
      if (drop[0] || drop[1]) oERR_ovf <= 1'b1;
      oCDB_en <= gnt_any;
      if (gnt_any) begin
        oCDB_nick <= cand_nick[gnt_src];
        oCDB_dt   <= cand_dt[gnt_src];
        oCDB_src  <= gnt_src;
        prio      <= ~gnt_src;
      end
    end
  end

  // FIFO storage stage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (rdy && !clr && !rst) begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          mem_nick[s][wptr[s]] <= in_nick[s];
          mem_dt[s][wptr[s]]   <= in_dt[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts every
// broadcast; a separate monitor compares what appears on the bus.
module tb_cdb_arbiter;
  localparam int DEPTH = 4;
  localparam int NW    = 6;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst, rdy, clr;
  logic          iEX_en, iSLB_en;
  logic [NW-1:0] iEX_nick, iSLB_nick;
  logic [DW-1:0] iEX_dt, iSLB_dt;
  logic          oEX_full, oSLB_full, oCDB_en, oCDB_src, oERR_ovf;
  logic [NW-1:0] oCDB_nick;
  logic [DW-1:0] oCDB_dt;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .NICK_W(NW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
    .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt),
    .oEX_full(oEX_full), .oSLB_full(oSLB_full),
    .oCDB_en(oCDB_en), .oCDB_nick(oCDB_nick), .oCDB_dt(oCDB_dt),
    .oCDB_src(oCDB_src), .oERR_ovf(oERR_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          src;
    logic [NW-1:0] nick;
    logic [DW-1:0] dt;
  } ent_t;

  ent_t qe[$], qs[$], exp_q[$];
  bit   m_prio, m_ovf;
  int   errors = 0, checks = 0;

  logic          prev_en, prev_src;
  logic [NW-1:0] prev_nick;
  logic [DW-1:0] prev_dt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ent_t mk(input logic src, input logic [NW-1:0] n, input logic [DW-1:0] d);
    ent_t e;
    e.src = src; e.nick = n; e.dt = d;
    return e;
  endfunction

  // Reference model: applies one clock edge's worth of the arbitration rules.
  task automatic model_edge();
    bit ae, as_, ce, cs, g, be, bs;
    ent_t it;
    if (rst || (rdy && clr)) begin
      qe.delete(); qs.delete();
      m_prio = 1'b0; m_ovf = 1'b0;
    end else if (rdy) begin
      ae = iEX_en && (iEX_nick != 0);
      as_ = iSLB_en && (iSLB_nick != 0);
      ce = (qe.size() != 0) || ae;
      cs = (qs.size() != 0) || as_;
      g  = (ce && cs) ? m_prio : cs;
      be = 1'b0; bs = 1'b0;
      if (ce || cs) begin
        if (!g) begin
          if (qe.size() != 0) it = qe.pop_front();
          else begin it = mk(1'b0, iEX_nick, iEX_dt); be = 1'b1; end
        end else begin
          if (qs.size() != 0) it = qs.pop_front();
          else begin it = mk(1'b1, iSLB_nick, iSLB_dt); bs = 1'b1; end
        end
        exp_q.push_back(it);
        m_prio = !g;
      end
      if (ae && !be) begin
        if (qe.size() < DEPTH) qe.push_back(mk(1'b0, iEX_nick, iEX_dt));
        else m_ovf = 1'b1;
      end
      if (as_ && !bs) begin
        if (qs.size() < DEPTH) qs.push_back(mk(1'b1, iSLB_nick, iSLB_dt));
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r_rst, input bit r_rdy, input bit r_clr,
                      input bit e_en, input logic [NW-1:0] e_nick, input logic [DW-1:0] e_dt,
                      input bit s_en, input logic [NW-1:0] s_nick, input logic [DW-1:0] s_dt);
    @(negedge clk);
    rst = r_rst; rdy = r_rdy; clr = r_clr;
    iEX_en = e_en; iEX_nick = e_nick; iEX_dt = e_dt;
    iSLB_en = s_en; iSLB_nick = s_nick; iSLB_dt = s_dt;
    model_edge();
    @(posedge clk);
    #1;
    check("ex_full", oEX_full, qe.size() >= DEPTH - 1);
    check("slb_full", oSLB_full, qs.size() >= DEPTH - 1);
    check("ovf", oERR_ovf, m_ovf);
    if (!r_rst && !r_rdy) begin
      check("hold_en", oCDB_en, prev_en);
      check("hold_nick", oCDB_nick, prev_nick);
      check("hold_dt", oCDB_dt, prev_dt);
      check("hold_src", oCDB_src, prev_src);
    end
    prev_en = oCDB_en; prev_nick = oCDB_nick; prev_dt = oCDB_dt; prev_src = oCDB_src;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic both_push(input int n, input int base);
    for (int i = 0; i < n; i++)
      step(0, 1, 0, 1, NW'((i % 7) + 1), DW'(base + i), 1, NW'(((i + 3) % 7) + 1), DW'(base + 'h80 + i));
  endtask

  // Monitor: every active edge either produces the predicted broadcast or nothing.
  initial begin
    bit act;
    ent_t e;
    forever begin
      @(posedge clk);
      act = rst || rdy;
      #1;
      if (act) begin
        check("cdb_en", oCDB_en, exp_q.size() != 0);
        if (oCDB_en && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("cdb_nick", oCDB_nick, e.nick);
          check("cdb_dt", oCDB_dt, e.dt);
          check("cdb_src", oCDB_src, e.src);
        end else if (exp_q.size() != 0) begin
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    int rr_ord[8] = '{1, 5, 2, 6, 3, 7, 4, 8};
    bit saw_full;
    rst = 1; rdy = 1; clr = 0;
    iEX_en = 0; iEX_nick = 0; iEX_dt = 0;
    iSLB_en = 0; iSLB_nick = 0; iSLB_dt = 0;

    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_en", oCDB_en, 0);
    check("rst_nick", oCDB_nick, 0);
    check("rst_dt", oCDB_dt, 0);
    check("rst_src", oCDB_src, 0);
    check("rst_fulls", {oEX_full, oSLB_full, oERR_ovf}, 0);

    step(0, 1, 0, 1, 3, 'h11, 0, 0, 0);
    check("first_en", oCDB_en, 1);
    check("first_nick", oCDB_nick, 3);
    check("first_dt", oCDB_dt, 'h11);
    check("first_src", oCDB_src, 0);
    idle(1);
    check("first_pulse_end", oCDB_en, 0);

    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 1, NW'(i + 1), DW'('h100 + i), 1, NW'(i + 5), DW'('h200 + i));
      check("rr_en", oCDB_en, 1);
      check("rr_order", oCDB_nick, rr_ord[i]);
    end
    for (int i = 4; i < 8; i++) begin
      idle(1);
      check("rr_en", oCDB_en, 1);
      check("rr_order", oCDB_nick, rr_ord[i]);
    end
    idle(1);
    check("rr_done", oCDB_en, 0);

    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    saw_full = 0;
    for (int i = 0; i < 10; i++) begin
      both_push(1, 'h300 + i * 2);
      if (oEX_full) saw_full = 1;
    end
    check("ovf_full_seen", saw_full, 1);
    check("ovf_set", oERR_ovf, 1);
    idle(12);
    check("ovf_sticky", oERR_ovf, 1);

    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    check("clr_ovf", oERR_ovf, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0, 1, 0, DW'('h55 + i));
      check("tag0_en", oCDB_en, 0);
    end
    check("tag0_flags", {oSLB_full, oERR_ovf}, 0);

    both_push(6, 'h400);
    step(0, 1, 1, 1, 9, 'h999, 1, 10, 'haaa);
    check("clr_en", oCDB_en, 0);
    check("clr_flags", {oEX_full, oSLB_full, oERR_ovf}, 0);
    idle(6);

    both_push(6, 'h500);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, i[0], NW'(i + 11), DW'($urandom), !i[0], NW'(i + 20), DW'($urandom));
    idle(12);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1, NW'($urandom_range(0, 7)), DW'($urandom),
           $urandom_range(0, 2) != 0, NW'($urandom_range(0, 7)), DW'($urandom));
    idle(12);
    check("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
